lc3_decode_stage: RTL and testbench
===================================

# lc3_decode_stage

Registered decode stage of the LC3 pipeline: the RTL that consumes the decode_in interface (enable_decode, dout, npc_in). On each enabled clock it captures the fetched instruction and its next-PC, then produces the execute, writeback and memory control words for the downstream execute stage. Outputs are registered with one-cycle latency and hold their value while the stage is stalled.

## Interface
Parameters:
- none (all widths fixed by the LC3 ISA: 16-bit data/address).

Ports:
- clock  input  1  pipeline clock; all state updates on posedge.
- reset  input  1  synchronous, active-high; one clock; priority over all other inputs.
- enable_decode  input  1  capture/decode strobe from the control unit; 0 = stall (hold).
- dout  input  16  instruction word from instruction memory.
- npc_in  input  16  PC+1 of the instruction on dout.
- IR  output  16  registered copy of captured instruction.
- npc_out  output  16  registered copy of captured npc_in.
- E_Control  output  6  {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}.
- W_Control  output  2  writeback source select.
- Mem_Control  output  1  1 = indirect memory access (LDI/STI).
- illegal_op  output  1  1 = captured opcode not supported by this pipeline.

## Operation
- Opcode = dout[15:12]. Decode is combinational from dout; every output is a flop.
- alu_control: ADD (0001) 00, AND (0101) 01, NOT (1001) 10; all other opcodes 00.
- op2select: ADD/AND with dout[5]=0 -> 1 (register VSR2); dout[5]=1 -> 0 (imm5). NOT -> 1. All others 0.
- pcselect1/pcselect2:
  - BR (0000), LD (0010), LDI (1010), LEA (1110), ST (0011), STI (1011): 01 (offset9), pcselect2=1 (npc base).
  - LDR (0110), STR (0111): 10 (offset6), pcselect2=0 (base register).
  - JMP (1100): 11 (zero offset), pcselect2=0.
  - ALU ops and illegal: 00, 0.
- W_Control: ALU ops 00; LD/LDR/LDI 01 (memory); LEA 10 (PC-relative address); all others 00.
- Mem_Control: 1 for LDI, STI only.
- Illegal opcodes (0100, 1000, 1101, 1111): E_Control=0, W_Control=0, Mem_Control=0, illegal_op=1; IR and npc_out still captured. illegal_op=0 for all supported opcodes.
- No arithmetic performed; npc_in passes through unmodified (no increment, no wrap handling).

## Timing
- Reset (sampled high at posedge): IR=16'h0000, npc_out=16'h0000, E_Control=6'h00, W_Control=2'b00, Mem_Control=0, illegal_op=0. Note 16'h0000 decodes as BR with nzp=000 (no-op); reset value of controls is all-zero regardless.
- reset and enable_decode both high: reset wins.
- Reset asserted mid-stream: outputs clear at that edge; first post-reset capture on first edge with reset=0 and enable_decode=1.
- enable_decode=1, reset=0 at edge N: all outputs reflect dout/npc_in sampled at edge N, visible after edge N (latency 1 cycle).
- enable_decode=0: every output holds, even if dout/npc_in change; no partial updates.
- Back-to-back enables: a new instruction decoded every cycle, throughput 1/clock.
- No handshake beyond enable_decode; no backpressure output.

## Test plan
- Reset: reset=1 for 2 clocks with enable_decode=1, dout=16'h1234, npc_in=16'h3000 -> all outputs 0; deassert, next enabled edge captures.
- ADD reg / AND imm / NOT: dout=16'h1283, npc_in=16'h3001 -> IR=16'h1283, npc_out=16'h3001, E_Control=6'h01, W=00, Mem=0; next cycle dout=16'h5265 -> E_Control=6'h10; then 16'h927F -> E_Control=6'h21.
- LDI / LEA: dout=16'hA405, npc_in=16'h3010 -> E_Control=6'h06, W_Control=01, Mem_Control=1; dout=16'hE405 -> E_Control=6'h06, W_Control=10, Mem_Control=0.
- STR / JMP: dout=16'h7442 -> E_Control=6'h08, W=00, Mem=0; dout=16'hC1C0 -> E_Control=6'h0C.
- Stall: capture 16'h1283, then enable_decode=0 for 3 clocks while dout=16'hA405, npc_in=16'h3050 -> outputs unchanged; re-enable -> LDI values appear one clock later.
- Illegal and reset priority: dout=16'hF025 -> IR=16'hF025, controls 0, illegal_op=1; then reset=1 with enable_decode=1, dout=16'h1283 -> all outputs 0 including illegal_op.

Source files
------------

// File: rtl/lc3_decode_stage.sv
// lc3_decode_stage
// ----------------
// Registered decode stage of the LC3 pipeline. On each enabled clock the
// fetched instruction and its next-PC are captured. The execute, writeback
// and memory control words for the execute stage are captured in the same
// edge. Every output is a flop with one cycle of latency. All outputs hold
// while enable_decode is low.
//
// Ports:
//   clock          in   1   pipeline clock, all updates on posedge
//   reset          in   1   synchronous active-high reset, beats everything
//   enable_decode  in   1   capture strobe; 0 = stall (hold all outputs)
//   dout           in  16   instruction word from instruction memory
//   npc_in         in  16   PC+1 of the instruction on dout
//   IR             out 16   captured instruction
//   npc_out        out 16   captured npc_in (passed through unmodified)
//   E_Control      out  6   {alu_control[1:0], pcselect1[1:0], pcselect2, op2select}
//   W_Control      out  2   writeback source: 00 ALU, 01 memory, 10 PC-relative
//   Mem_Control    out  1   indirect memory access (LDI/STI)
//   illegal_op     out  1   captured opcode is not supported by this pipeline
module lc3_decode_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        enable_decode,
  input  logic [15:0] dout,
  input  logic [15:0] npc_in,
  output logic [15:0] IR,
  output logic [15:0] npc_out,
  output logic [5:0]  E_Control,
  output logic [1:0]  W_Control,
  output logic        Mem_Control,
  output logic        illegal_op
);

  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_LD  = 4'b0010;
  localparam logic [3:0] OP_ST  = 4'b0011;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;
  localparam logic [3:0] OP_LDI = 4'b1010;
  localparam logic [3:0] OP_STI = 4'b1011;
  localparam logic [3:0] OP_JMP = 4'b1100;
  localparam logic [3:0] OP_LEA = 4'b1110;

  logic [3:0]  opcode;
  logic [1:0]  alu_control_d;
  logic [1:0]  pcselect1_d;
  logic        pcselect2_d;
  logic        op2select_d;
  logic [1:0]  w_control_d;
  logic        mem_control_d;
  logic        illegal_d;

  logic [15:0] ir_q;
  logic [15:0] npc_q;
  logic [5:0]  e_control_q;
  logic [1:0]  w_control_q;
  logic        mem_control_q;
  logic        illegal_q;

  assign opcode = dout[15:12];

  // Decode: combinational from the incoming instruction word
  always_comb begin
    alu_control_d = 2'b00;
    pcselect1_d   = 2'b00;
    pcselect2_d   = 1'b0;
    op2select_d   = 1'b0;
    w_control_d   = 2'b00;
    mem_control_d = 1'b0;
    illegal_d     = 1'b0;
    unique case (opcode)
      OP_ADD: begin
        alu_control_d = 2'b00;
        // dout[5] selects imm5 (1) versus the second source register (0)
        op2select_d   = ~dout[5];
      end
      OP_AND: begin
        alu_control_d = 2'b01;
        op2select_d   = ~dout[5];
      end
      OP_NOT: begin
        alu_control_d = 2'b10;
        op2select_d   = 1'b1;
      end
      OP_BR, OP_ST: begin
        pcselect1_d = 2'b01;
        pcselect2_d = 1'b1;
      end
      OP_LD: begin
        pcselect1_d = 2'b01;
        pcselect2_d = 1'b1;
        w_control_d = 2'b01;
      end
      OP_LDI: begin
        pcselect1_d   = 2'b01;
        pcselect2_d   = 1'b1;
        w_control_d   = 2'b01;
        mem_control_d = 1'b1;
      end
      OP_STI: begin
        pcselect1_d   = 2'b01;
        pcselect2_d   = 1'b1;
        mem_control_d = 1'b1;
      end
      OP_LEA: begin
        pcselect1_d = 2'b01;
        pcselect2_d = 1'b1;
        w_control_d = 2'b10;
      end
      OP_LDR: begin
        pcselect1_d = 2'b10;
        w_control_d = 2'b01;
      end
      OP_STR: begin
        pcselect1_d = 2'b10;
      end
      OP_JMP: begin
        pcselect1_d = 2'b11;
      end
      default: begin
        // 0100, 1000, 1101, 1111: the control words stay zero and only the
        // flag is raised
        illegal_d = 1'b1;
      end
    endcase
  end

  // Stage register: capture on enable, hold on stall
  always_ff @(posedge clock) begin
    if (reset) begin
      ir_q          <= 16'h0000;
      npc_q         <= 16'h0000;
      e_control_q   <= 6'h00;
      w_control_q   <= 2'b00;
      mem_control_q <= 1'b0;
      illegal_q     <= 1'b0;
    end else if (enable_decode) begin
      ir_q          <= dout;
      npc_q         <= npc_in;
      e_control_q   <= {alu_control_d, pcselect1_d, pcselect2_d, op2select_d};
      w_control_q   <= w_control_d;
      mem_control_q <= mem_control_d;
      illegal_q     <= illegal_d;
    end
  end

  assign IR          = ir_q;
  assign npc_out     = npc_q;
  assign E_Control   = e_control_q;
  assign W_Control   = w_control_q;
  assign Mem_Control = mem_control_q;
  assign illegal_op  = illegal_q;

endmodule

// File: tb/tb_lc3_decode_stage.sv
module tb_lc3_decode_stage;

  logic        clock;
  logic        reset;
  logic        enable_decode;
  logic [15:0] dout;
  logic [15:0] npc_in;
  logic [15:0] IR;
  logic [15:0] npc_out;
  logic [5:0]  E_Control;
  logic [1:0]  W_Control;
  logic        Mem_Control;
  logic        illegal_op;

  lc3_decode_stage dut (
    .clock         (clock),
    .reset         (reset),
    .enable_decode (enable_decode),
    .dout          (dout),
    .npc_in        (npc_in),
    .IR            (IR),
    .npc_out       (npc_out),
    .E_Control     (E_Control),
    .W_Control     (W_Control),
    .Mem_Control   (Mem_Control),
    .illegal_op    (illegal_op)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [15:0] ir;
    logic [15:0] npc;
    logic [5:0]  e;
    logic [1:0]  w;
    logic        m;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  exp_t held;
  int   checks = 0;
  int   errors = 0;

  // Expected control words for {opcode, 12'h0C0} (dout[5]=0), opcode 0..15
  logic [5:0] e_tab [16] = '{6'h06, 6'h01, 6'h06, 6'h06, 6'h00, 6'h11, 6'h08, 6'h08,
                             6'h00, 6'h21, 6'h06, 6'h06, 6'h0C, 6'h00, 6'h06, 6'h00};
  logic [1:0] w_tab [16] = '{2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00,
                             2'b00, 2'b00, 2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 2'b00};
  logic       m_tab [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                             1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic       i_tab [16] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                             1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  task automatic cmp(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    checks++;
    assert (obs === expv)
      else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
  endtask

  function automatic exp_t mk(input logic [15:0] ir, input logic [15:0] npc,
                              input logic [5:0] e, input logic [1:0] w,
                              input logic m, input logic ill);
    exp_t r;
    r.ir = ir; r.npc = npc; r.e = e; r.w = w; r.m = m; r.ill = ill;
    return r;
  endfunction

  // Drive one cycle of stimulus, queue its expected result, then compare
  // once the edge has produced output.
  task automatic step(input string tag, input logic r, input logic en,
                      input logic [15:0] d, input logic [15:0] n, input exp_t e);
    exp_t got;
    reset = r; enable_decode = en; dout = d; npc_in = n;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=empty-queue expected=entry", tag);
    end else begin
      got = exp_q.pop_front();
      cmp({tag, ".IR"},      IR,                  got.ir);
      cmp({tag, ".npc"},     npc_out,             got.npc);
      cmp({tag, ".E"},       {10'd0, E_Control},  {10'd0, got.e});
      cmp({tag, ".W"},       {14'd0, W_Control},  {14'd0, got.w});
      cmp({tag, ".Mem"},     {15'd0, Mem_Control}, {15'd0, got.m});
      cmp({tag, ".illegal"}, {15'd0, illegal_op}, {15'd0, got.ill});
    end
  endtask

  exp_t zero;

  initial begin
    zero = mk(16'h0000, 16'h0000, 6'h00, 2'b00, 1'b0, 1'b0);
    reset = 1'b1; enable_decode = 1'b1; dout = 16'h1234; npc_in = 16'h3000;

    // Reset for two clocks with enable high
    step("rst0", 1'b1, 1'b1, 16'h1234, 16'h3000, zero);
    step("rst1", 1'b1, 1'b1, 16'h1234, 16'h3000, zero);

    // ALU ops, back to back
    step("add_reg", 1'b0, 1'b1, 16'h1283, 16'h3001, mk(16'h1283, 16'h3001, 6'h01, 2'b00, 1'b0, 1'b0));
    step("and_imm", 1'b0, 1'b1, 16'h5265, 16'h3002, mk(16'h5265, 16'h3002, 6'h10, 2'b00, 1'b0, 1'b0));
    step("not",     1'b0, 1'b1, 16'h927F, 16'h3003, mk(16'h927F, 16'h3003, 6'h21, 2'b00, 1'b0, 1'b0));

    // Memory / address ops
    step("ldi", 1'b0, 1'b1, 16'hA405, 16'h3010, mk(16'hA405, 16'h3010, 6'h06, 2'b01, 1'b1, 1'b0));
    step("lea", 1'b0, 1'b1, 16'hE405, 16'h3011, mk(16'hE405, 16'h3011, 6'h06, 2'b10, 1'b0, 1'b0));
    step("str", 1'b0, 1'b1, 16'h7442, 16'h3012, mk(16'h7442, 16'h3012, 6'h08, 2'b00, 1'b0, 1'b0));
    step("jmp", 1'b0, 1'b1, 16'hC1C0, 16'h3013, mk(16'hC1C0, 16'h3013, 6'h0C, 2'b00, 1'b0, 1'b0));

    // Stall: outputs hold while inputs change
    held = mk(16'h1283, 16'h3020, 6'h01, 2'b00, 1'b0, 1'b0);
    step("cap", 1'b0, 1'b1, 16'h1283, 16'h3020, held);
    for (int i = 0; i < 3; i++)
      step("stall", 1'b0, 1'b0, 16'hA405, 16'h3050, held);
    step("resume", 1'b0, 1'b1, 16'hA405, 16'h3050, mk(16'hA405, 16'h3050, 6'h06, 2'b01, 1'b1, 1'b0));

    // Illegal opcode, then stall holds the flag
    held = mk(16'hF025, 16'h3060, 6'h00, 2'b00, 1'b0, 1'b1);
    step("illegal", 1'b0, 1'b1, 16'hF025, 16'h3060, held);
    step("ill_hold", 1'b0, 1'b0, 16'h1283, 16'h3061, held);

    // Reset wins over enable, then first post-reset capture
    step("rst_pri", 1'b1, 1'b1, 16'h1283, 16'h3070, zero);
    step("rst_stall", 1'b0, 1'b0, 16'h1283, 16'h3071, zero);
    step("post_rst", 1'b0, 1'b1, 16'h1283, 16'h3072, mk(16'h1283, 16'h3072, 6'h01, 2'b00, 1'b0, 1'b0));

    // Sweep every opcode with dout[5]=0
    for (int op = 0; op < 16; op++) begin
      logic [15:0] ins;
      logic [15:0] pc;
      ins = {op[3:0], 12'h0C0};
      pc  = 16'h4000 + 16'(op);
      step("sweep", 1'b0, 1'b1, ins, pc, mk(ins, pc, e_tab[op], w_tab[op], m_tab[op], i_tab[op]));
    end

    // Immediate forms of ADD/AND clear op2select
    step("add_imm", 1'b0, 1'b1, 16'h1021, 16'hFFFF, mk(16'h1021, 16'hFFFF, 6'h00, 2'b00, 1'b0, 1'b0));
    step("and_imm2", 1'b0, 1'b1, 16'h5020, 16'h0000, mk(16'h5020, 16'h0000, 6'h10, 2'b00, 1'b0, 1'b0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
